// File: rtl/prng_pkg.sv
// Shared definitions for the xorshift PRNG stream: FSM states, known
// full-period shift triples and the fallback seed.
package prng_pkg;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2
  } prng_state_e;

  // Full-period xorshift triples (left, right, left) per state width
  localparam int TRIPLE8_A  = 3;
  localparam int TRIPLE8_B  = 5;
  localparam int TRIPLE8_C  = 4;
  localparam int TRIPLE16_A = 7;
  localparam int TRIPLE16_B = 9;
  localparam int TRIPLE16_C = 8;
  localparam int TRIPLE32_A = 13;
  localparam int TRIPLE32_B = 17;
  localparam int TRIPLE32_C = 5;

  // An all-zero xorshift state is a fixed point, so zero seeds are replaced
  localparam logic [63:0] PRNG_DEFAULT_SEED = 64'hACE1;

  // True when a shift amount is usable for a given state width
  function automatic bit shift_ok(input int amount, input int width);
    return (amount >= 1) && (amount <= width - 1);
  endfunction

endpackage

// File: rtl/xorshift_step.sv
// One combinational xorshift step: left, right, left shift-xor stages,
// every intermediate kept at the state width.
module xorshift_step #(
  parameter int WIDTH   = 16,
  parameter int SHIFT_A = 7,
  parameter int SHIFT_B = 9,
  parameter int SHIFT_C = 8
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;

  assign x1 = x  ^ (x  << SHIFT_A);
  assign x2 = x1 ^ (x1 >> SHIFT_B);
  assign y  = x2 ^ (x2 << SHIFT_C);

endmodule

// File: rtl/xorshift_prng_stream.sv
// Seeded xorshift generator with zero-seed guard, warm-up discard and a
// valid/ready output stream drawing one word per accepted handshake.
module xorshift_prng_stream
  import prng_pkg::*;
#(
  parameter int          WIDTH        = 16,
  parameter int          SHIFT_A      = TRIPLE16_A,
  parameter int          SHIFT_B      = TRIPLE16_B,
  parameter int          SHIFT_C      = TRIPLE16_C,
  parameter int          OUT_W        = 8,
  parameter int          WARMUP       = 2,
  parameter logic [63:0] DEFAULT_SEED = PRNG_DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [OUT_W-1:0] rnd_data,
  output logic             seeded
);

  localparam logic [WIDTH-1:0] SEED_FALLBACK = DEFAULT_SEED[WIDTH-1:0];
  localparam logic [7:0]       WARMUP_LAST   = 8'((WARMUP > 0) ? WARMUP - 1 : 0);

  // Reject parameter sets that would break the generator or the stream
  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("xorshift_prng_stream: WIDTH must be 8..64");
  end
  if (!shift_ok(SHIFT_A, WIDTH) || !shift_ok(SHIFT_B, WIDTH) ||
      !shift_ok(SHIFT_C, WIDTH)) begin : g_bad_shift
    $error("xorshift_prng_stream: shifts must be 1..WIDTH-1");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_bad_outw
    $error("xorshift_prng_stream: OUT_W must be 1..WIDTH");
  end
  if (WARMUP < 0 || WARMUP > 255) begin : g_bad_warmup
    $error("xorshift_prng_stream: WARMUP must be 0..255");
  end
  if (SEED_FALLBACK == '0) begin : g_bad_seed
    $error("xorshift_prng_stream: DEFAULT_SEED must be non-zero at WIDTH");
  end

  prng_state_e      fsm;
  prng_state_e      fsm_next;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_next;
  logic [WIDTH-1:0] stepped;
  logic [7:0]       cnt;
  logic [7:0]       cnt_next;
  logic             seeded_next;

  xorshift_step #(
    .WIDTH   (WIDTH),
    .SHIFT_A (SHIFT_A),
    .SHIFT_B (SHIFT_B),
    .SHIFT_C (SHIFT_C)
  ) u_step (
    .x (state),
    .y (stepped)
  );

  // Registered generator state, FSM, warm-up counter and seeded flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= ST_UNSEEDED;
      state  <= '0;
      cnt    <= '0;
      seeded <= 1'b0;
    end else begin
      fsm    <= fsm_next;
      state  <= state_next;
      cnt    <= cnt_next;
      seeded <= seeded_next;
    end
  end

  // Next-state logic: a seed load overrides everything, including a handshake
  always_comb begin
    fsm_next    = fsm;
    state_next  = state;
    cnt_next    = cnt;
    seeded_next = seeded;
    if (seed_valid) begin
      state_next  = (seed_data == '0) ? SEED_FALLBACK : seed_data;
      cnt_next    = '0;
      seeded_next = 1'b1;
      fsm_next    = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
    end else begin
      case (fsm)
        ST_WARMUP: begin
          state_next = stepped;
          cnt_next   = cnt + 8'd1;
          if (cnt == WARMUP_LAST) begin
            fsm_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (rnd_ready) begin
            state_next = stepped;
          end
        end
        default: begin
          state_next = state;
        end
      endcase
    end
  end

  assign rnd_valid = (fsm == ST_RUN);
  assign rnd_data  = state[WIDTH-1 -: OUT_W];

endmodule

// File: doc/xorshift_prng_stream.md
Name: xorshift_prng_stream

Overview:
- Parametrised successor of the team's 8-bit xorshift microtile: WIDTH-bit xorshift generator with configurable shift triple.
- Adds explicit seed loading, zero-seed guard, a warm-up phase that discards initial words, and a valid/ready output stream.
- Sits between a seed source (host pins or config register) and any consumer that draws one random word per accepted handshake.

Parameters:
- WIDTH, 16, generator state width in bits; legal range 8..64.
- SHIFT_A, 7, first left-shift amount; must be 1..WIDTH-1.
- SHIFT_B, 9, right-shift amount; must be 1..WIDTH-1.
- SHIFT_C, 8, second left-shift amount; must be 1..WIDTH-1.
- OUT_W, 8, output word width; taken from the state MSBs; must be 1..WIDTH.
- WARMUP, 2, steps discarded after each seed load; 0..255.
- DEFAULT_SEED, 16'hACE1 (zero-extended or truncated to WIDTH), substituted for an all-zero seed; must itself be non-zero.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seed_valid  input  1  load seed_data this cycle; always accepted.
- seed_data  input  WIDTH  seed value.
- rnd_valid  output  1  rnd_data holds a valid word.
- rnd_ready  input  1  consumer accepts rnd_data when rnd_valid is high.
- rnd_data  output  OUT_W  random word, equal to state[WIDTH-1 -: OUT_W].
- seeded  output  1  high once any seed has been loaded since reset.

Behaviour:
- Reset (async assert, sync release): state = 0, FSM = UNSEEDED, warm-up counter = 0, rnd_valid = 0, seeded = 0. rnd_data therefore reads 0.
- Step function, fully combinational, one step per cycle, all intermediates truncated to WIDTH:
  - x1 = x ^ (x << SHIFT_A)
  - x2 = x1 ^ (x1 >> SHIFT_B)
  - x3 = x2 ^ (x2 << SHIFT_C)
- FSM state UNSEEDED: rnd_valid = 0; state holds.
- FSM state WARMUP: rnd_valid = 0; state steps every cycle and the counter increments; after WARMUP steps, go to RUN.
- FSM state RUN: rnd_valid = 1.
  - On rnd_valid & rnd_ready, state steps once and the next word appears the following cycle (zero-bubble; back-to-back accepts give one word per cycle).
  - Without ready, state and rnd_data hold stable.
- Seed load, from any FSM state, when seed_valid = 1:
  - Next cycle: state = seed_data, or DEFAULT_SEED if seed_data == 0.
  - Counter = 0, seeded = 1, FSM = WARMUP (or RUN directly if WARMUP = 0).
  - rnd_valid is 0 in the cycle after the load when WARMUP > 0.
- Simultaneous seed_valid and accepted handshake: the consumer's word counts as consumed; the seed load wins and no step is applied.
- Reseed mid-warm-up restarts warm-up from 0.
- State never becomes zero after seeding, because a non-zero xorshift state maps to non-zero.
- Latency from seed load to first valid word: WARMUP+1 cycles.
- Reset asserted mid-stream: rnd_valid drops asynchronously; no partial step is retained.
- Elaboration-time checks fail on illegal parameter combinations.

Decomposition:
- Shared package prng_pkg holds:
  - FSM state enum (UNSEEDED, WARMUP, RUN).
  - Known full-period triples as named constants: 8-bit (3,5,4), 16-bit (7,9,8), 32-bit (13,17,5).
  - Default seed constant.
- One natural sub-module: xorshift_step, a combinational next-state function parametrised by WIDTH and the three shifts. It is reused by the bench's reference model.

Test Plan:
- Reset with rnd_ready = 1 and no seed for 10 cycles -> rnd_valid = 0, rnd_data = 0x00, seeded = 0 throughout.
- Seed 16'h0001 with default parameters, rnd_ready = 1 -> warm-up states 0x8181 then 0x6021; rnd_valid rises 3 cycles after the load with rnd_data = 0x60; each following cycle matches the xorshift_step model.
- Seed 16'h0000 -> state loads 16'hACE1; the output sequence equals that of an explicit seed of ACE1.
- In RUN, hold rnd_ready = 0 for 5 cycles -> rnd_data stable, no step; on ready, exactly one advance per accepted cycle.
- seed_valid coincident with an accepted handshake, and a reseed during warm-up -> state equals the new seed, counter restarts, rnd_valid low for WARMUP+1 cycles.
- Assert rst_n low mid-stream between clock edges -> rnd_valid and seeded drop immediately; after release, the block stays UNSEEDED until the next seed.
